dma_line_copier: RTL
====================

// Module: dma_line_copier
// PURPOSE
//  Parametrised multi-line DMA copy engine on the mem_cntrl op/io_address/data-bus interface.
//  On start, reads NUM lines from src_addr into an internal line buffer, then writes each line back to dst_addr.
//  This generalises the fixed single-line loopback: width, depth, addresses and line count are configurable,
//  and it adds start/busy/done control, abort and a short-read error.
//  Sits between the control/register block and mem_cntrl.
// PARAMETERS
//  DATA_W      32  data bus width in bits (multiple of 8)
//  ADDR_W      64  io_address width
//  LINE_WORDS  16  words per line; power of 2, >=2
//  CNT_W       16  width of the num_lines request field
// PORTS
//  clk                  in   1       clock, all logic on posedge
//  rst_n                in   1       asynchronous active-low reset
//  start                in   1       1-cycle request; sampled only in IDLE
//  abort                in   1       cancel transfer; priority over all other events
//  src_addr             in   ADDR_W  source base byte address, latched on accepted start
//  dst_addr             in   ADDR_W  destination base byte address, latched on accepted start
//  num_lines            in   CNT_W   number of lines to copy, latched on accepted start
//  busy                 out  1       high in every state except IDLE
//  done                 out  1       1-cycle pulse on completion; not pulsed on abort
//  err_short            out  1       sticky; tx_done on a read before LINE_WORDS rd_valid; cleared on accepted start
//  tx_done              in   1       mem_cntrl: current read/write burst finished
//  rd_valid             in   1       mem_cntrl: common_data_bus_in holds valid read word
//  op                   out  2       00 NOP, 01 READ, 11 WRITE
//  io_address           out  ADDR_W  line base byte address for the current burst
//  common_data_bus_in   in   DATA_W  read data
//  common_data_bus_out  out  DATA_W  write data
// BEHAVIOUR
//  - Reset (async): state IDLE; op=00; io_address=0; bus_out=0; busy=0; done=0; err_short=0.
//    Clears the buffer, word index widx and line index lidx.
//  - LINE_BYTES = LINE_WORDS*DATA_W/8.
//    Address = base + lidx*LINE_BYTES, computed mod 2^ADDR_W (wrap-around allowed, no error).
//  - States: IDLE, READ, WPRIME, WRITE, DONE.
//  - IDLE
//    - start && num_lines!=0: latch src_addr, dst_addr and num_lines; lidx=0; widx=0; -> READ.
//    - start && num_lines==0: -> DONE with no bus traffic.
//  - READ
//    - op=01; io_address=src line address.
//    - Each rd_valid: buf[widx]<=bus_in; widx++ (wraps mod LINE_WORDS).
//    - tx_done: -> WPRIME; widx<=0. A rd_valid in the same cycle is still captured first.
//    - If fewer than LINE_WORDS words were captured, set err_short and keep going; unwritten words keep stale data.
//  - WPRIME (1 cycle)
//    - op=11; io_address=dst line address; bus_out=buf[0]; widx held.
//  - WRITE
//    - op=11; bus_out=buf[widx]; widx++ every cycle, wrapping mod LINE_WORDS.
//    - tx_done:
//      - if lidx==num_lines-1: -> DONE.
//      - else lidx++, widx<=0, -> READ.
//  - DONE (1 cycle): done=1, busy=1; -> IDLE.
//  - op=00, io_address=0 and bus_out=0 in IDLE and DONE.
//  - All outputs are decoded combinationally from registered state; no output depends on same-cycle inputs.
//  - start outside IDLE is ignored; latched parameters do not change mid-transfer.
//  - abort in any non-IDLE state: next edge -> IDLE, op=00, no done pulse, err_short held; buffer not cleared.
//  - abort and start in the same cycle in IDLE: start is ignored.
//  - tx_done in IDLE or DONE is ignored.
//  - rd_valid outside READ is ignored.
//  - Reset asserted mid-transfer: immediate return to reset values; no partial done.
// TESTING
//  - 1 line, src=0x0, dst=0x400, 16 rd_valid words 0xA0..0xAF, then tx_done:
//    -> op 01 then 11; write data 0xA0..0xAF in order from WPRIME; done pulse; err_short=0.
//  - num_lines=3, src=0x1000, dst=0x2000:
//    -> read addresses 0x1000/0x1040/0x1080; write addresses 0x2000/0x2040/0x2080; exactly one done.
//  - num_lines=0 start:
//    -> DONE next cycle; op stays 00 throughout; done high for 1 cycle.
//  - tx_done after only 10 rd_valid:
//    -> err_short=1 until next start; transfer still completes with done.
//  - abort during WRITE of line 2 of 4:
//    -> IDLE next cycle, op=00, no done; new start accepted and clears err_short.
//  - rst_n low mid-READ, and src=0xFFFF_FFFF_FFFF_FFC0 with 2 lines:
//    -> outputs at reset values immediately; second line address wraps to 0x0.

Source files
------------

// File: rtl/dma_line_copier.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module  : dma_line_copier                                                  |
// | Brief   : Multi-line DMA copy engine: reads lines into a buffer, writes    |
// |           them back to a destination on the mem_cntrl op/address bus.     |
// | Revision: 1.0  initial release                                             |
// +----------------------------------------------------------------------------+
module dma_line_copier #(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 64,
  parameter int LINE_WORDS = 16,
  parameter int CNT_W      = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [ADDR_W-1:0] src_addr,
  input  logic [ADDR_W-1:0] dst_addr,
  input  logic [CNT_W-1:0]  num_lines,
  output logic              busy,
  output logic              done,
  output logic              err_short,
  input  logic              tx_done,
  input  logic              rd_valid,
  output logic [1:0]        op,
  output logic [ADDR_W-1:0] io_address,
  input  logic [DATA_W-1:0] common_data_bus_in,
  output logic [DATA_W-1:0] common_data_bus_out
);

  localparam int c_WIDX_W     = $clog2(LINE_WORDS);
  localparam int c_RCNT_W     = c_WIDX_W + 1;
  localparam int c_LINE_BYTES = LINE_WORDS * DATA_W / 8;
  localparam logic [1:0] c_OP_NOP   = 2'b00;
  localparam logic [1:0] c_OP_READ  = 2'b01;
  localparam logic [1:0] c_OP_WRITE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_READ   = 3'd1,
    S_WPRIME = 3'd2,
    S_WRITE  = 3'd3,
    S_DONE   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_next;
  logic [ADDR_W-1:0]   r_src;
  logic [ADDR_W-1:0]   r_dst;
  logic [CNT_W-1:0]    r_num;
  logic [CNT_W-1:0]    r_lidx;
  logic [c_WIDX_W-1:0] r_widx;
  logic [c_RCNT_W-1:0] r_rcnt;
  logic                r_err_short;
  logic [DATA_W-1:0]   r_line_buf [LINE_WORDS];

  logic                w_accept;
  logic                w_last_line;
  logic [c_RCNT_W-1:0] w_rcnt_sum;
  logic [ADDR_W-1:0]   w_offset;

  assign w_accept    = start && !abort;
  assign w_last_line = (r_lidx == r_num - 1'b1);
  // words captured by the end of this cycle, including a rd_valid coincident with tx_done
  assign w_rcnt_sum  = r_rcnt + {{(c_RCNT_W-1){1'b0}}, rd_valid};
  assign w_offset    = ADDR_W'(r_lidx) * ADDR_W'(c_LINE_BYTES);

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:   if (w_accept) w_next = (num_lines != '0) ? S_READ : S_DONE;
      S_READ:   if (abort) w_next = S_IDLE; else if (tx_done) w_next = S_WPRIME;
      S_WPRIME: w_next = abort ? S_IDLE : S_WRITE;
      S_WRITE:  if (abort) w_next = S_IDLE;
                else if (tx_done) w_next = w_last_line ? S_DONE : S_READ;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_src       <= '0;
      r_dst       <= '0;
      r_num       <= '0;
      r_lidx      <= '0;
      r_widx      <= '0;
      r_rcnt      <= '0;
      r_err_short <= 1'b0;
      for (int i = 0; i < LINE_WORDS; i++) r_line_buf[i] <= '0;
    end else begin
      r_state <= w_next;
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_src       <= src_addr;
            r_dst       <= dst_addr;
            r_num       <= num_lines;
            r_lidx      <= '0;
            r_widx      <= '0;
            r_rcnt      <= '0;
            r_err_short <= 1'b0;
          end
        end
        S_READ: begin
          if (!abort) begin
            if (rd_valid) begin
              r_line_buf[r_widx] <= common_data_bus_in;
              r_widx             <= r_widx + 1'b1;
              if (r_rcnt != c_RCNT_W'(LINE_WORDS)) r_rcnt <= r_rcnt + 1'b1;
            end
            if (tx_done) begin
              r_widx <= '0;
              if (w_rcnt_sum < c_RCNT_W'(LINE_WORDS)) r_err_short <= 1'b1;
            end
          end
        end
        S_WRITE: begin
          if (!abort) begin
            if (tx_done && !w_last_line) begin
              r_lidx <= r_lidx + 1'b1;
              r_widx <= '0;
              r_rcnt <= '0;
            end else begin
              r_widx <= r_widx + 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    op                  = c_OP_NOP;
    io_address          = '0;
    common_data_bus_out = '0;
    case (r_state)
      S_READ: begin
        op         = c_OP_READ;
        io_address = r_src + w_offset;
      end
      S_WPRIME, S_WRITE: begin
        op                  = c_OP_WRITE;
        io_address          = r_dst + w_offset;
        common_data_bus_out = r_line_buf[r_widx];
      end
      default: ;
    endcase
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign err_short = r_err_short;

endmodule
`default_nettype wire
